fifo_write_arbiter: RTL and testbench

//  Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.

---
 rtl/fifo_write_arbiter.sv | 93 +++++++++
 tb/tb_fifo_write_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter onto a single FIFO write port: one IDLE cycle to arbitrate, then up to BURST_LEN beats.
// sig_Full stalls the owner (no ready, no write); an owner dropping valid ends its burst early.
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int PTR_WIDTH  = 2,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_Valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_Data,
   output logic [NUM_REQ-1:0]            req_Ready,
   input  logic                          sig_Full,
   output logic                          write_Enable,
   output logic [DATA_WIDTH-1:0]         buffer_Input,
   output logic                          grant_Active,
   output logic [PTR_WIDTH-1:0]          grant_Owner
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t               state;
   logic [PTR_WIDTH-1:0] rr_ptr;
   logic [CNT_WIDTH-1:0] count;

   logic                 pick_found;
   logic [PTR_WIDTH-1:0] pick_idx;
   logic                 owner_valid;
   logic                 in_burst;
   logic                 last_beat;
   logic [PTR_WIDTH-1:0] next_ptr;

   // Scan downward so the requester closest to rr_ptr is the last, winning assignment.
   always_comb begin
      logic [PTR_WIDTH-1:0] idx;
      pick_found = 1'b0;
      pick_idx   = rr_ptr;
      idx        = rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = rr_ptr + PTR_WIDTH'(k);
         if (req_Valid[idx]) begin
            pick_found = 1'b1;
            pick_idx   = idx;
         end
      end
   end

   assign owner_valid  = req_Valid[grant_Owner];
   // Reset suppresses the strobe in the cycle it is asserted, so an aborted burst writes nothing more.
   assign in_burst     = (state == BURST) && !reset;
   assign last_beat    = (count == CNT_WIDTH'(BURST_LEN - 1));
   assign next_ptr     = grant_Owner + PTR_WIDTH'(1);

   assign write_Enable = in_burst && owner_valid && !sig_Full;
   assign req_Ready    = (in_burst && !sig_Full) ? (NUM_REQ'(1) << grant_Owner) : '0;
   assign buffer_Input = in_burst ? req_Data[grant_Owner*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign grant_Active = (state == BURST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_Owner <= '0;
         count       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_Owner <= pick_idx;
                  count       <= '0;
                  state       <= BURST;
               end
            end
            BURST: begin
               if (!owner_valid) begin
                  state  <= IDLE;
                  rr_ptr <= next_ptr;
               end else if (!sig_Full) begin
                  count <= count + CNT_WIDTH'(1);
                  if (last_beat) begin
                     state  <= IDLE;
                     rr_ptr <= next_ptr;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus a random phase, checked every cycle against a burst model.
module tb_fifo_write_arbiter;
   localparam int N  = 4;
   localparam int BL = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req_Valid;
   logic [31:0] req_Data;
   logic [3:0]  req_Ready;
   logic        sig_Full;
   logic        write_Enable;
   logic [7:0]  buffer_Input;
   logic        grant_Active;
   logic [1:0]  grant_Owner;

   fifo_write_arbiter dut (
      .clock        (clock),
      .reset        (reset),
      .req_Valid    (req_Valid),
      .req_Data     (req_Data),
      .req_Ready    (req_Ready),
      .sig_Full     (sig_Full),
      .write_Enable (write_Enable),
      .buffer_Input (buffer_Input),
      .grant_Active (grant_Active),
      .grant_Owner  (grant_Owner)
   );

   initial forever #5 clock = ~clock;

   int vectors    = 0;
   int miscompares = 0;

   // Stimulus knobs: prem = words left per producer (-1 = endless), pdat = producer's current word.
   int         prem [N];
   logic [7:0] pdat [N];
   int         wcnt [N];
   logic       rst, full, rnd;

   // Reference model: is a burst running, whose, how many beats so far, where the next scan starts.
   bit m_busy;
   int m_owner, m_beats, m_ptr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      logic [3:0]  v;
      logic [31:0] d;
      logic        e_we;
      logic [3:0]  e_rdy;
      logic [7:0]  e_dat;
      logic        e_run;
      for (int i = 0; i < N; i++) begin
         v[i] = (prem[i] != 0) && (!rnd || ($urandom_range(0, 1) == 1));
         d[i*8 +: 8] = pdat[i];
      end
      if (rnd) begin
         full = ($urandom_range(0, 3) == 0);
         rst  = ($urandom_range(0, 49) == 0);
      end
      req_Valid = v;
      req_Data  = d;
      sig_Full  = full;
      reset     = rst;

      e_run = m_busy && !rst;
      e_we  = e_run && v[m_owner] && !full;
      e_rdy = (e_run && !full) ? 4'(1 << m_owner) : 4'h0;
      e_dat = e_run ? pdat[m_owner] : 8'h00;

      @(negedge clock);
      check("write_Enable", {31'b0, write_Enable}, {31'b0, e_we});
      check("req_Ready",    {28'b0, req_Ready},    {28'b0, e_rdy});
      check("buffer_Input", {24'b0, buffer_Input}, {24'b0, e_dat});
      check("grant_Active", {31'b0, grant_Active}, {31'b0, m_busy});
      check("grant_Owner",  {30'b0, grant_Owner},  m_owner);

      for (int i = 0; i < N; i++) begin
         if (v[i] && e_rdy[i]) begin
            pdat[i] = pdat[i] + 8'd1;
            if (prem[i] > 0) prem[i]--;
         end
      end
      if (e_we) wcnt[m_owner]++;

      @(posedge clock);
      if (rst) begin
         m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
      end else if (!m_busy) begin
         for (int k = 0; k < N; k++) begin
            if (!m_busy && v[(m_ptr + k) % N]) begin
               m_busy  = 1;
               m_owner = (m_ptr + k) % N;
               m_beats = 0;
            end
         end
      end else if (!v[m_owner]) begin
         m_busy = 0;
         m_ptr  = (m_owner + 1) % N;
      end else if (!full) begin
         m_beats++;
         if (m_beats == BL) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
         end
      end
      #1;
   endtask

   task automatic restart();
      rst = 1; full = 0; rnd = 0;
      for (int i = 0; i < N; i++) begin
         prem[i] = 0;
         pdat[i] = 8'(i << 6);
      end
      cycle();
      rst = 0;
      for (int i = 0; i < N; i++) wcnt[i] = 0;
   endtask

   initial begin
      reset = 1; req_Valid = '0; req_Data = '0; sig_Full = 0;
      rst = 1; full = 0; rnd = 0;
      m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) begin prem[i] = 0; pdat[i] = 8'h00; wcnt[i] = 0; end
      @(posedge clock); #1;

      // 1: reset held with every producer valid, then first grant goes to 0.
      for (int i = 0; i < N; i++) prem[i] = -1;
      cycle(); cycle();
      rst = 0;
      cycle();
      check("t1_owner",  {30'b0, grant_Owner}, 0);
      check("t1_active", {31'b0, grant_Active}, 1);

      // 2: single producer with six words A0..A5.
      restart();
      prem[2] = 6; pdat[2] = 8'hA0;
      repeat (9) cycle();
      check("t2_words", wcnt[2], 6);
      for (int i = 0; i < N; i++) prem[i] = -1;
      cycle();
      check("t2_next_owner", {30'b0, grant_Owner}, 3);

      // 3: all producers busy; rotation 0,1,2,3,0.
      restart();
      for (int i = 0; i < N; i++) prem[i] = -1;
      repeat (25) cycle();
      check("t3_w0", wcnt[0], 8);
      check("t3_w1", wcnt[1], 4);
      check("t3_w2", wcnt[2], 4);
      check("t3_w3", wcnt[3], 4);

      // 4: owner 1 stalled by full for three cycles after two beats.
      restart();
      prem[1] = 8;
      repeat (3) cycle();
      full = 1;
      repeat (3) cycle();
      check("t4_stall_words", wcnt[1], 2);
      full = 0;
      repeat (2) cycle();
      check("t4_words", wcnt[1], 4);
      prem[2] = 5;
      cycle();
      check("t4_next_owner", {30'b0, grant_Owner}, 2);

      // 5: owner 3 drops after one beat; pointer wraps to 0.
      restart();
      prem[3] = 1;
      cycle();
      prem[0] = -1;
      repeat (4) cycle();
      check("t5_w3", wcnt[3], 1);
      check("t5_owner", {30'b0, grant_Owner}, 0);
      check("t5_active", {31'b0, grant_Active}, 1);

      // 6: reset lands on beat 2 of owner 1.
      restart();
      prem[1] = -1;
      repeat (3) cycle();
      rst = 1;
      cycle();
      rst = 0;
      check("t6_words", wcnt[1], 2);
      check("t6_active", {31'b0, grant_Active}, 0);
      prem[0] = -1;
      cycle();
      check("t6_owner", {30'b0, grant_Owner}, 0);

      // Random traffic, backpressure and occasional resets.
      restart();
      for (int i = 0; i < N; i++) prem[i] = -1;
      rnd = 1;
      repeat (400) cycle();
      rnd = 0; rst = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
